// File: rtl/wb_buffer.sv
// wb_buffer: two-entry writeback FIFO between the memory stage and the
// register-file write port. It selects each instruction's result, queues it,
// and drains one entry per cycle whenever the write port is free.
// Optional feature macro: WB_FWD_EN builds the operand-forwarding comparators.
// When WB_FWD_EN is undefined, fwd_hit1/2 and fwd_data1/2 are tied to zero.
module wb_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [1:0]  in_sel,
  input  logic        in_we,
  input  logic [15:0] in_mem_out,
  input  logic [15:0] in_alu_out,
  input  logic [15:0] in_pc,
  input  logic        rf_busy,
  output logic        rf_we,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_wdata,
  input  logic [2:0]  fwd_addr1,
  input  logic [2:0]  fwd_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [15:0] fwd_data1,
  output logic [15:0] fwd_data2,
  output logic [15:0] retire_count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  // Entry 0 is always the head and entry 1 the younger one.
  logic [1:0]  count;
  logic [2:0]  addr0;
  logic [2:0]  addr1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        we0;
  logic        we1;

  logic [15:0] result;
  logic [2:0]  new_addr;
  logic        new_we;
  logic        head_valid;
  logic        push;
  logic        pop;

  assign head_valid = (count != 2'd0);
  assign in_ready   = (count < FULL_COUNT);
  assign push       = in_valid & in_ready;
  assign pop        = head_valid & ~rf_busy;
  assign new_addr   = in_instr[12:10];
  // r0 is hard-wired, so a write to it is demoted to a no-op entry.
  assign new_we     = in_we & (new_addr != 3'd0);

  // Result selection for the instruction being accepted.
  always_comb begin
    result = 16'h0000;
    case (in_sel)
      2'b00:   result = in_mem_out;
      2'b01:   result = in_alu_out;
      2'b10:   result = in_pc + 16'd1;
      2'b11:   result = 16'h0000;
      default: result = 16'h0000;
    endcase
  end

  // FIFO storage, occupancy and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= 2'd0;
      addr0        <= 3'd0;
      addr1        <= 3'd0;
      data0        <= 16'h0000;
      data1        <= 16'h0000;
      we0          <= 1'b0;
      we1          <= 1'b0;
      retire_count <= 16'h0000;
    end else begin
      if (push && pop) begin
        // Only reachable with one entry: the new entry becomes the head.
        addr0 <= new_addr;
        data0 <= result;
        we0   <= new_we;
      end else if (pop) begin
        addr0 <= addr1;
        data0 <= data1;
        we0   <= we1;
        count <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          addr0 <= new_addr;
          data0 <= result;
          we0   <= new_we;
        end else begin
          addr1 <= new_addr;
          data1 <= result;
          we1   <= new_we;
        end
        count <= count + 2'd1;
      end else begin
        count <= count;
      end
      if (pop) begin
        retire_count <= retire_count + 16'd1;
      end else begin
        retire_count <= retire_count;
      end
    end
  end

  assign rf_we    = head_valid & we0 & ~rf_busy;
  assign rf_addr  = head_valid ? addr0 : 3'd0;
  assign rf_wdata = head_valid ? data0 : 16'h0000;

`ifdef WB_FWD_EN
  // Youngest matching pending write wins; result is {hit, data}.
  function automatic logic [16:0] fwd_lookup(
    input logic [2:0]  addr,
    input logic [1:0]  cnt,
    input logic [2:0]  a0,
    input logic [15:0] d0,
    input logic        w0,
    input logic [2:0]  a1,
    input logic [15:0] d1,
    input logic        w1
  );
    logic [16:0] res;
    res = 17'd0;
    if (addr == 3'd0) begin
      res = 17'd0;
    end else if ((cnt == 2'd2) && w1 && (a1 == addr)) begin
      res = {1'b1, d1};
    end else if ((cnt != 2'd0) && w0 && (a0 == addr)) begin
      res = {1'b1, d0};
    end else begin
      res = 17'd0;
    end
    return res;
  endfunction

  logic [16:0] fwd1;
  logic [16:0] fwd2;

  // Forwarding lookups for both operand ports.
  always_comb begin
    fwd1 = fwd_lookup(fwd_addr1, count, addr0, data0, we0, addr1, data1, we1);
    fwd2 = fwd_lookup(fwd_addr2, count, addr0, data0, we0, addr1, data1, we1);
  end

  assign fwd_hit1  = fwd1[16];
  assign fwd_data1 = fwd1[15:0];
  assign fwd_hit2  = fwd2[16];
  assign fwd_data2 = fwd2[15:0];
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_data1  = 16'h0000;
  assign fwd_hit2   = 1'b0;
  assign fwd_data2  = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Testbench for wb_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [1:0]  in_sel;
  logic        in_we;
  logic [15:0] in_mem_out;
  logic [15:0] in_alu_out;
  logic [15:0] in_pc;
  logic        rf_busy;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic [2:0]  fwd_addr1;
  logic [2:0]  fwd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
  logic [15:0] retire_count;

  wb_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_sel(in_sel), .in_we(in_we), .in_mem_out(in_mem_out),
    .in_alu_out(in_alu_out), .in_pc(in_pc), .rf_busy(rf_busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        we;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_retire = 16'h0000;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;

`ifdef WB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] sel_result(input logic [1:0] sel, input logic [15:0] mem,
                                             input logic [15:0] alu, input logic [15:0] pc);
    if (sel == 2'b00) return mem;
    if (sel == 2'b01) return alu;
    if (sel == 2'b10) return pc + 16'd1;
    return 16'h0000;
  endfunction

  // Youngest matching pending write: scan the queue from the tail.
  function automatic logic [16:0] model_fwd(input logic [2:0] a);
    if (!FWD_ON || a == 3'd0) return 17'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].we && q[i].addr == a) return {1'b1, q[i].data};
    return 17'd0;
  endfunction

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    bit   do_pop, do_push;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_retire = 16'h0000;
    end else begin
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && !rf_busy;
      e.addr  = in_instr[12:10];
      e.data  = sel_result(in_sel, in_mem_out, in_alu_out, in_pc);
      e.we    = in_we && (in_instr[12:10] != 3'd0);
      if (do_pop) begin
        void'(q.pop_front());
        m_retire = m_retire + 16'd1;
      end
      if (do_push) q.push_back(e);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [16:0] f1, f2;
    if (chk_en) begin
      f1 = model_fwd(fwd_addr1);
      f2 = model_fwd(fwd_addr2);
      check("in_ready", {15'd0, in_ready}, {15'd0, q.size() < 2});
      check("rf_we", {15'd0, rf_we}, {15'd0, (q.size() > 0) && q[0].we && !rf_busy});
      check("rf_addr", {13'd0, rf_addr}, (q.size() > 0) ? {13'd0, q[0].addr} : 16'h0000);
      check("rf_wdata", rf_wdata, (q.size() > 0) ? q[0].data : 16'h0000);
      check("retire_count", retire_count, m_retire);
      check("fwd_hit1", {15'd0, fwd_hit1}, {15'd0, f1[16]});
      check("fwd_data1", fwd_data1, f1[15:0]);
      check("fwd_hit2", {15'd0, fwd_hit2}, {15'd0, f2[16]});
      check("fwd_data2", fwd_data2, f2[15:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [1:0] sel, input logic we,
                          input logic [15:0] mem, input logic [15:0] alu, input logic [15:0] pc);
    in_instr = instr; in_sel = sel; in_we = we;
    in_mem_out = mem; in_alu_out = alu; in_pc = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; in_sel = 2'b00; in_we = 1'b0;
    in_mem_out = 16'h0000; in_alu_out = 16'h0000; in_pc = 16'h0000; rf_busy = 1'b0;
    fwd_addr1 = 3'd0; fwd_addr2 = 3'd0;
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_rf_we", {15'd0, rf_we}, 16'd0);
    check("rst_retire", retire_count, 16'h0000);
    rst_n = 1'b1;
    step();

    // Basic ALU result, one-cycle latency to rf_we.
    push_one(16'h0401, 2'b01, 1'b1, 16'h0000, 16'h1234, 16'h0000);
    @(negedge clk);
    check("t1_rf_we", {15'd0, rf_we}, 16'd1);
    check("t1_rf_addr", {13'd0, rf_addr}, 16'd1);
    check("t1_rf_wdata", rf_wdata, 16'h1234);
    step();
    @(negedge clk);
    check("t1_retire", retire_count, 16'd1);

    // PC+1 wrap, then memory data.
    push_one(16'h0800, 2'b10, 1'b1, 16'h0000, 16'h0000, 16'hFFFF);
    @(negedge clk);
    check("t2_pc_wrap", rf_wdata, 16'h0000);
    check("t2_addr", {13'd0, rf_addr}, 16'd2);
    push_one(16'h0C00, 2'b00, 1'b1, 16'hBEEF, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t2_mem", rf_wdata, 16'hBEEF);
    step();
    @(negedge clk);
    check("t2_retire", retire_count, 16'd3);

    // Fill while the write port is busy, then drain in order.
    rf_busy = 1'b1;
    push_one(16'h1000, 2'b01, 1'b1, 16'h0000, 16'h0AAA, 16'h0000);
    push_one(16'h1400, 2'b01, 1'b1, 16'h0000, 16'h0BBB, 16'h0000);
    @(negedge clk);
    check("t3_full_ready", {15'd0, in_ready}, 16'd0);
    check("t3_busy_we", {15'd0, rf_we}, 16'd0);
    step();
    rf_busy = 1'b0;
    @(negedge clk);
    check("t3_d0_we", {15'd0, rf_we}, 16'd1);
    check("t3_d0_addr", {13'd0, rf_addr}, 16'd4);
    check("t3_d0_data", rf_wdata, 16'h0AAA);
    step();
    @(negedge clk);
    check("t3_d1_addr", {13'd0, rf_addr}, 16'd5);
    check("t3_d1_data", rf_wdata, 16'h0BBB);
    step();
    @(negedge clk);
    check("t3_retire", retire_count, 16'd5);
    check("t3_empty_we", {15'd0, rf_we}, 16'd0);

    // Write to r0 is suppressed but still retires.
    push_one(16'h0001, 2'b01, 1'b1, 16'h0000, 16'h5555, 16'h0000);
    @(negedge clk);
    check("t4_r0_we", {15'd0, rf_we}, 16'd0);
    step();
    @(negedge clk);
    check("t4_retire", retire_count, 16'd6);

    // Forwarding: youngest of two r3 writes wins.
    rf_busy = 1'b1;
    push_one(16'h0C00, 2'b01, 1'b1, 16'h0000, 16'h1111, 16'h0000);
    push_one(16'h0C00, 2'b01, 1'b1, 16'h0000, 16'h2222, 16'h0000);
    fwd_addr1 = 3'd3;
    fwd_addr2 = 3'd4;
    @(negedge clk);
    check("t5_hit1", {15'd0, fwd_hit1}, FWD_ON ? 16'd1 : 16'd0);
    check("t5_data1", fwd_data1, FWD_ON ? 16'h2222 : 16'h0000);
    check("t5_hit2", {15'd0, fwd_hit2}, 16'd0);

    // Reset while full discards pending entries.
    rf_busy = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", {15'd0, in_ready}, 16'd1);
    check("t6_we", {15'd0, rf_we}, 16'd0);
    check("t6_retire", retire_count, 16'h0000);
    step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = 16'($urandom);
      in_sel     = 2'($urandom_range(0, 3));
      in_we      = ($urandom_range(0, 4) != 0);
      in_mem_out = 16'($urandom);
      in_alu_out = 16'($urandom);
      in_pc      = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      rf_busy    = ($urandom_range(0, 2) == 0);
      fwd_addr1  = 3'($urandom_range(0, 7));
      fwd_addr2  = 3'($urandom_range(0, 7));
      rst_n      = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
